frame_stats: RTL and testbench

FRAME_STATS -- requirements
Module: frame_stats

---
 rtl/frame_stats_pkg.sv | 22 ++
 rtl/frame_stats_if.sv | 13 +
 rtl/frame_stats_regs.sv | 72 +++++++
 rtl/frame_stats.sv | 129 ++++++++++++
 tb/tb_frame_stats.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_stats_pkg.sv
// Shared constants for the frame statistics block: register map, FSM state codes
// and accumulator widths.
package frame_stats_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_STATUS    = 1;
    localparam int REG_MIN       = 2;
    localparam int REG_MAX       = 3;
    localparam int REG_SUM_LO    = 4;
    localparam int REG_SUM_HI    = 5;
    localparam int REG_COUNT     = 6;
    localparam int REG_FRAME_CNT = 7;

    // Sum is DATA_WIDTH + SUM_EXT_W bits wide; count and frame counter are COUNT_W bits.
    localparam int SUM_EXT_W = 32;
    localparam int COUNT_W   = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

endpackage

// File: rtl/frame_stats_if.sv
// Register bus between a host and frame_stats: single-cycle write, registered read.
interface frame_stats_if #(
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] addr_rel_i;
    logic                  wr_i;
    logic                  rd_i;
    logic [31:0]           datawr_i;
    logic [31:0]           datard_o;

    modport master (output addr_rel_i, wr_i, rd_i, datawr_i, input datard_o);
    modport slave  (input addr_rel_i, wr_i, rd_i, datawr_i, output datard_o);
endinterface

// File: rtl/frame_stats_regs.sv
// Register file for frame_stats: bus decode, CTRL/STATUS, SUM_HI hold register
// and the registered read mux.
module frame_stats_regs
    import frame_stats_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    frame_stats_if.slave                    bus,
    input  logic                            latch,
    input  logic                            count_sat,
    input  logic [DATA_WIDTH-1:0]           stat_min,
    input  logic [DATA_WIDTH-1:0]           stat_max,
    input  logic [DATA_WIDTH+SUM_EXT_W-1:0] stat_sum,
    input  logic [COUNT_W-1:0]              stat_count,
    input  logic [COUNT_W-1:0]              frame_cnt,
    output logic                            enable
);

    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr_ctrl;
    logic                  wr_status;
    logic                  valid;
    logic                  sat;
    logic [31:0]           sum_hi_hold;
    logic [31:0]           rd_val;
    logic                  unused_wdata;

    assign addr         = bus.addr_rel_i;
    assign wr_ctrl      = bus.wr_i && (addr == ADDR_WIDTH'(REG_CTRL));
    assign wr_status    = bus.wr_i && (addr == ADDR_WIDTH'(REG_STATUS));
    assign unused_wdata = ^bus.datawr_i[31:2];

    always_comb begin
        rd_val = '0;
        case (addr)
            ADDR_WIDTH'(REG_CTRL):      rd_val = {31'b0, enable};
            ADDR_WIDTH'(REG_STATUS):    rd_val = {30'b0, sat, valid};
            ADDR_WIDTH'(REG_MIN):       rd_val = 32'(stat_min);
            ADDR_WIDTH'(REG_MAX):       rd_val = 32'(stat_max);
            ADDR_WIDTH'(REG_SUM_LO):    rd_val = stat_sum[31:0];
            ADDR_WIDTH'(REG_SUM_HI):    rd_val = sum_hi_hold;
            ADDR_WIDTH'(REG_COUNT):     rd_val = stat_count;
            ADDR_WIDTH'(REG_FRAME_CNT): rd_val = frame_cnt;
            default:                    rd_val = '0;
        endcase
    end

    // Status set from LATCH dominates a simultaneous write-1-to-clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            enable       <= 1'b0;
            valid        <= 1'b0;
            sat          <= 1'b0;
            sum_hi_hold  <= '0;
            bus.datard_o <= '0;
        end else begin
            if (wr_ctrl)
                enable <= bus.datawr_i[0];
            valid <= latch | (valid & ~(wr_status & bus.datawr_i[0]));
            sat   <= (latch & count_sat) | (sat & ~(wr_status & bus.datawr_i[1]));
            if (bus.rd_i) begin
                bus.datard_o <= rd_val;
                if (addr == ADDR_WIDTH'(REG_SUM_LO))
                    sum_hi_hold <= 32'(stat_sum >> SUM_EXT_W);
            end
        end
    end

endmodule

// File: rtl/frame_stats.sv
// Per-frame pixel statistics (min, max, sum, count, frame counter) with a
// one-cycle registered video pass-through.
module frame_stats
    import frame_stats_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_fv,
    input  logic                  in_dv,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_fv,
    output logic                  out_dv,
    output logic [DATA_WIDTH-1:0] out_data,
    frame_stats_if.slave          bus
);

    localparam int SUM_W = DATA_WIDTH + SUM_EXT_W;

    logic [1:0]            state;
    logic                  fv_q;
    logic                  enable;
    logic                  pix;
    logic                  frame_start;
    logic                  frame_end;
    logic                  latch;
    logic                  count_full;

    logic [DATA_WIDTH-1:0] w_min, w_max, base_min, base_max, upd_min, upd_max;
    logic [SUM_W-1:0]      w_sum, base_sum, upd_sum;
    logic [COUNT_W-1:0]    w_count, base_count, upd_count;

    logic [DATA_WIDTH-1:0] stat_min, stat_max;
    logic [SUM_W-1:0]      stat_sum;
    logic [COUNT_W-1:0]    stat_count, frame_cnt;

    assign pix         = in_fv & in_dv;
    assign frame_start = (state == S_IDLE) & enable & in_fv & ~fv_q;
    assign frame_end   = (state == S_ACCUM) & ~in_fv & fv_q;
    assign latch       = (state == S_LATCH);

    // In IDLE the update is computed from the frame-start values, so a pixel on
    // the rising-edge cycle is folded into the freshly initialised accumulators.
    always_comb begin
        base_min   = (state == S_IDLE) ? '1 : w_min;
        base_max   = (state == S_IDLE) ? '0 : w_max;
        base_sum   = (state == S_IDLE) ? '0 : w_sum;
        base_count = (state == S_IDLE) ? '0 : w_count;
        count_full = (base_count == '1);
        upd_min    = (in_data < base_min) ? in_data : base_min;
        upd_max    = (in_data > base_max) ? in_data : base_max;
        upd_sum    = count_full ? base_sum : base_sum + SUM_W'(in_data);
        upd_count  = count_full ? base_count : base_count + COUNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_fv     <= 1'b0;
            out_dv     <= 1'b0;
            out_data   <= '0;
            fv_q       <= 1'b0;
            state      <= S_IDLE;
            w_min      <= '1;
            w_max      <= '0;
            w_sum      <= '0;
            w_count    <= '0;
            stat_min   <= '1;
            stat_max   <= '0;
            stat_sum   <= '0;
            stat_count <= '0;
            frame_cnt  <= '0;
        end else begin
            out_fv   <= in_fv;
            out_dv   <= in_dv;
            out_data <= in_data;
            fv_q     <= in_fv;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state   <= S_ACCUM;
                        w_min   <= pix ? upd_min   : base_min;
                        w_max   <= pix ? upd_max   : base_max;
                        w_sum   <= pix ? upd_sum   : base_sum;
                        w_count <= pix ? upd_count : base_count;
                    end
                end
                S_ACCUM: begin
                    if (frame_end) begin
                        state <= S_LATCH;
                    end else if (pix) begin
                        w_min   <= upd_min;
                        w_max   <= upd_max;
                        w_sum   <= upd_sum;
                        w_count <= upd_count;
                    end
                end
                S_LATCH: begin
                    stat_min   <= w_min;
                    stat_max   <= w_max;
                    stat_sum   <= w_sum;
                    stat_count <= w_count;
                    frame_cnt  <= frame_cnt + COUNT_W'(1);
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    frame_stats_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_regs (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .latch      (latch),
        .count_sat  (w_count == '1),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .stat_sum   (stat_sum),
        .stat_count (stat_count),
        .frame_cnt  (frame_cnt),
        .enable     (enable)
    );

endmodule

// File: tb/tb_frame_stats.sv
// Bench for frame_stats: directed and random frames against a frame-level
// reference model that collects each frame's pixels and reduces them at frame end.
module tb_frame_stats;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_fv = 1'b0;
    logic        in_dv = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_fv, out_dv;
    logic [15:0] out_data;

    frame_stats_if #(.ADDR_WIDTH(4)) bus ();

    frame_stats #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_fv    (in_fv),
        .in_dv    (in_dv),
        .in_data  (in_data),
        .out_fv   (out_fv),
        .out_dv   (out_dv),
        .out_data (out_data),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic        m_en, m_valid, m_sat, m_prev, m_active, m_pend;
    logic [15:0] m_min, m_max, p_min, p_max;
    logic [47:0] m_sum, p_sum;
    logic [31:0] m_cnt, m_fcnt, m_hold, m_rdata, p_cnt, rdata;
    logic [15:0] pq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_reg(input int a);
        case (a)
            0:       return {31'b0, m_en};
            1:       return {30'b0, m_sat, m_valid};
            2:       return {16'b0, m_min};
            3:       return {16'b0, m_max};
            4:       return m_sum[31:0];
            5:       return m_hold;
            6:       return m_cnt;
            7:       return m_fcnt;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_valid = 0; m_sat = 0; m_prev = 0; m_active = 0; m_pend = 0;
        m_min = 16'hFFFF; m_max = 0; m_sum = 0; m_cnt = 0; m_fcnt = 0;
        m_hold = 0; m_rdata = 0;
        pq.delete();
    endtask

    task automatic reduce_frame();
        p_min = 16'hFFFF; p_max = 0; p_sum = 0; p_cnt = 0;
        foreach (pq[i]) begin
            if (pq[i] < p_min) p_min = pq[i];
            if (pq[i] > p_max) p_max = pq[i];
            if (p_cnt != 32'hFFFF_FFFF) begin
                p_sum = p_sum + 48'(pq[i]);
                p_cnt = p_cnt + 1;
            end
        end
    endtask

    // One clock: advance the model with the values the DUT sampled, then check.
    task automatic tick();
        int          a;
        logic        en_pre, pend_pre, xfv, xdv;
        logic [15:0] xd;
        @(posedge clk);
        xfv = reset_n ? in_fv : 1'b0;
        xdv = reset_n ? in_dv : 1'b0;
        xd  = reset_n ? in_data : 16'h0;
        if (!reset_n) begin
            model_reset();
        end else begin
            a        = int'(bus.addr_rel_i);
            en_pre   = m_en;
            pend_pre = m_pend;
            if (bus.rd_i) begin
                m_rdata = exp_reg(a);
                if (a == 4) m_hold = 32'(m_sum >> 32);
            end
            if (bus.wr_i && a == 0) m_en = bus.datawr_i[0];
            if (bus.wr_i && a == 1) begin
                if (bus.datawr_i[0]) m_valid = 0;
                if (bus.datawr_i[1]) m_sat = 0;
            end
            if (pend_pre) begin
                m_min = p_min; m_max = p_max; m_sum = p_sum; m_cnt = p_cnt;
                m_valid = 1;
                if (p_cnt == 32'hFFFF_FFFF) m_sat = 1;
                m_fcnt = m_fcnt + 1;
                m_pend = 0;
            end
            if (m_active && !in_fv && m_prev) begin
                reduce_frame();
                m_pend   = 1;
                m_active = 0;
            end else if (!m_active && !pend_pre && en_pre && in_fv && !m_prev) begin
                m_active = 1;
                pq.delete();
            end
            if (m_active && in_fv && in_dv) pq.push_back(in_data);
            m_prev = in_fv;
        end
        #1;
        check("out_fv", 32'(out_fv), 32'(xfv));
        check("out_dv", 32'(out_dv), 32'(xdv));
        check("out_data", 32'(out_data), 32'(xd));
        check("datard", bus.datard_o, m_rdata);
    endtask

    task automatic drive(input logic fv, input logic dv, input logic [15:0] d);
        in_fv = fv; in_dv = dv; in_data = d;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom), 16'($urandom));
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        bus.addr_rel_i = 4'(a); bus.datawr_i = d; bus.wr_i = 1'b1;
        tick();
        bus.wr_i = 1'b0;
    endtask

    task automatic bus_rd(input int a);
        bus.addr_rel_i = 4'(a); bus.rd_i = 1'b1;
        tick();
        bus.rd_i = 1'b0;
        rdata = bus.datard_o;
    endtask

    task automatic read_all();
        for (int a = 0; a < 10; a++) bus_rd(a);
        bus_rd(15);
    endtask

    // mode 0: random dv/data, 1: dv=1 constant val, 2: dv=0
    task automatic frame(input int n, input int mode, input logic [15:0] val);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       drive(1'b1, 1'($urandom), 16'($urandom));
                1:       drive(1'b1, 1'b1, val);
                default: drive(1'b1, 1'b0, 16'($urandom));
            endcase
        end
        idle(3);
    endtask

    logic [31:0] saved_fc;

    initial begin
        bus.addr_rel_i = '0; bus.wr_i = 0; bus.rd_i = 0; bus.datawr_i = '0;
        model_reset();

        // reset with a frame already running, then keep it running after release
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'($urandom));
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16'($urandom));
        idle(2);
        bus_rd(2); check("rst_min", rdata, 32'hFFFF);
        bus_rd(3); check("rst_max", rdata, 32'h0);
        bus_rd(1); check("rst_status", rdata, 32'h0);
        bus_rd(7); check("rst_frame_cnt", rdata, 32'h0);
        bus_rd(0); check("rst_ctrl", rdata, 32'h0);

        // basic frame 5, 300, 2
        bus_wr(0, 32'h1);
        bus_rd(0); check("ctrl_en", rdata, 32'h1);
        drive(1'b1, 1'b0, 16'd77);
        drive(1'b1, 1'b1, 16'd5);
        drive(1'b1, 1'b0, 16'd1);
        drive(1'b1, 1'b1, 16'd300);
        drive(1'b1, 1'b1, 16'd2);
        idle(3);
        bus_rd(2); check("b_min", rdata, 32'd2);
        bus_rd(3); check("b_max", rdata, 32'd300);
        bus_rd(4); check("b_sum_lo", rdata, 32'd307);
        bus_rd(5); check("b_sum_hi", rdata, 32'd0);
        bus_rd(6); check("b_count", rdata, 32'd3);
        bus_rd(1); check("b_status", rdata, 32'h1);
        bus_rd(7); check("b_frame_cnt", rdata, 32'd1);

        // random frames
        for (int f = 0; f < 4; f++) begin
            frame($urandom_range(5, 40), 0, 16'h0);
            read_all();
        end

        // fully random fv/dv/data stream
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 7) == 0) ? ~in_fv : in_fv, 1'($urandom), 16'($urandom));
        idle(3);
        read_all();

        // frame without any qualified pixel
        bus_rd(7); saved_fc = rdata;
        frame(10, 2, 16'h0);
        bus_rd(2); check("e_min", rdata, 32'hFFFF);
        bus_rd(3); check("e_max", rdata, 32'h0);
        bus_rd(4); check("e_sum", rdata, 32'h0);
        bus_rd(6); check("e_count", rdata, 32'h0);
        bus_rd(7); check("e_frame_cnt", rdata, saved_fc + 1);

        // W1C in the LATCH cycle loses to the set; later W1C clears
        bus_wr(1, 32'h1);
        bus_rd(1); check("w1c_pre", rdata, 32'h0);
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 16'($urandom));
        drive(1'b0, 1'b0, 16'h0);
        bus_wr(1, 32'h1);
        bus_rd(1); check("w1c_set_wins", rdata, 32'h1);
        bus_wr(1, 32'h1);
        bus_rd(1); check("w1c_clear", rdata, 32'h0);

        // read of FRAME_CNT in the LATCH cycle returns the old count
        bus_rd(7); saved_fc = rdata;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 16'($urandom));
        drive(1'b0, 1'b0, 16'h0);
        bus_rd(7); check("latch_read_old", rdata, saved_fc);
        idle(1);
        bus_rd(7); check("latch_read_new", rdata, saved_fc + 1);

        // enable raised mid-frame: that frame is ignored, the next one latches
        bus_wr(0, 32'h0);
        bus_rd(7); saved_fc = rdata;
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16'($urandom));
        in_fv = 1'b1; in_dv = 1'b1;
        bus_wr(0, 32'h1);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 16'($urandom));
        idle(3);
        bus_rd(7); check("midfr_en_fc", rdata, saved_fc);
        frame(12, 0, 16'h0);
        bus_rd(7); check("midfr_next_fc", rdata, saved_fc + 1);
        read_all();

        // reset pulse in the middle of a 50-pixel frame
        for (int i = 0; i < 50; i++) begin
            reset_n = !(i == 25 || i == 26);
            drive(1'b1, 1'b1, 16'($urandom));
        end
        reset_n = 1'b1;
        idle(3);
        bus_rd(2); check("r_min", rdata, 32'hFFFF);
        bus_rd(3); check("r_max", rdata, 32'h0);
        bus_rd(4); check("r_sum", rdata, 32'h0);
        bus_rd(6); check("r_count", rdata, 32'h0);
        bus_rd(1); check("r_status", rdata, 32'h0);
        bus_rd(7); check("r_frame_cnt", rdata, 32'h0);
        bus_wr(0, 32'h1);
        frame(128, 1, 16'hFFFF);
        bus_rd(4); check("f128_sum_lo", rdata, 32'h007F_FF80);
        bus_rd(5); check("f128_sum_hi", rdata, 32'h0);
        bus_rd(6); check("f128_count", rdata, 32'd128);
        bus_rd(2); check("f128_min", rdata, 32'hFFFF);

        // sum crossing 32 bits and the SUM_HI hold register
        frame(65600, 1, 16'hFFFF);
        bus_rd(4); check("big_sum_lo", rdata, 32'h003E_FFC0);
        bus_rd(5); check("big_sum_hi", rdata, 32'h1);
        frame(10, 2, 16'h0);
        bus_rd(5); check("hold_kept", rdata, 32'h1);
        bus_rd(4); check("hold_lo_zero", rdata, 32'h0);
        bus_rd(5); check("hold_hi_zero", rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
